// File: rtl/foo_req_arbiter.sv
// Round-robin arbiter that shares one addressed req/ack target between NUM_REQ
// requesters. Each transaction is IDLE -> WAIT -> RESP -> IDLE, ending in an ACK or ERR pulse.
module foo_req_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 2,
  parameter  int TIMEOUT = 15,
  parameter  int TO_W    = 4,
  localparam int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                      CLK_IN,
  input  logic                      RST_IN,
  input  logic [NUM_REQ-1:0]        REQ_VEC_IN,
  input  logic [NUM_REQ*ADDR_W-1:0] ADDR_VEC_IN,
  output logic [NUM_REQ-1:0]        ACK_VEC_OUT,
  output logic [NUM_REQ-1:0]        ERR_VEC_OUT,
  output logic [ADDR_W-1:0]         MY_ADDR_OUT,
  output logic                      REQ_OUT,
  input  logic                      ACK_IN,
  output logic                      BUSY_OUT,
  output logic [GID_W-1:0]          GRANT_ID_OUT
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic [GID_W-1:0]    last_q, last_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [GID_W-1:0]    win;

  // First requester at or after last_grant+1, wrapping around.
  always_comb begin
    logic             found;
    logic [GID_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && REQ_VEC_IN[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    ack_d   = '0;
    err_d   = '0;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|REQ_VEC_IN) begin
          gid_d   = win;
          last_d  = win;
          addr_d  = ADDR_VEC_IN[win*ADDR_W +: ADDR_W];
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // ACK takes priority over a timeout expiring on the same edge.
        if (ACK_IN) begin
          req_d        = 1'b0;
          ack_d[gid_q] = 1'b1;
          state_d      = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          req_d        = 1'b0;
          err_d[gid_q] = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      gid_q   <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ACK_VEC_OUT  = ack_q;
  assign ERR_VEC_OUT  = err_q;
  assign MY_ADDR_OUT  = addr_q;
  assign REQ_OUT      = req_q;
  assign BUSY_OUT     = busy_q;
  assign GRANT_ID_OUT = gid_q;

endmodule

// File: tb/tb_foo_req_arbiter.sv
// Directed bench for foo_req_arbiter: reset, single request, round-robin order,
// timeout, ACK/timeout collision, mid-transaction disturbances, async reset.
module tb_foo_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vec;
  logic [7:0] addr_vec;
  logic [3:0] ack_vec, err_vec;
  logic [1:0] my_addr;
  logic       req_out, ack_in, busy;
  logic [1:0] gid;

  int checks = 0;
  int errors = 0;

  foo_req_arbiter #(.NUM_REQ(4), .ADDR_W(2), .TIMEOUT(15), .TO_W(4)) dut (
    .CLK_IN(clk), .RST_IN(rst), .REQ_VEC_IN(req_vec), .ADDR_VEC_IN(addr_vec),
    .ACK_VEC_OUT(ack_vec), .ERR_VEC_OUT(err_vec), .MY_ADDR_OUT(my_addr),
    .REQ_OUT(req_out), .ACK_IN(ack_in), .BUSY_OUT(busy), .GRANT_ID_OUT(gid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grant, immediate ACK, RESP; requester drops its bit on seeing the pulse.
  task automatic rr_txn(input int exp_id);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_id;
    tick();
    chk("rr_grant", 32'(gid), 32'(exp_id));
    chk("rr_req_out", 32'(req_out), 32'd1);
    ack_in = 1'b1;
    tick();
    chk("rr_ack", 32'(ack_vec), 32'(onehot));
    ack_in  = 1'b0;
    req_vec = req_vec & ~onehot;
    tick();
    chk("rr_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    req_vec  = '0;
    addr_vec = '0;
    ack_in   = 1'b0;
    tick();
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    chk("rst_ack", 32'(ack_vec), 32'd0);
    chk("rst_err", 32'(err_vec), 32'd0);
    chk("rst_addr", 32'(my_addr), 32'd0);
    tick();
    rst = 1'b0;

    // Single request: requester 2, address 3, ack on first WAIT cycle
    req_vec  = 4'b0100;
    addr_vec = 8'b00_11_00_00;
    tick();
    chk("t1_gid", 32'(gid), 32'd2);
    chk("t1_addr", 32'(my_addr), 32'd3);
    chk("t1_req_out", 32'(req_out), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_no_ack_yet", 32'(ack_vec), 32'd0);
    ack_in = 1'b1;
    tick();
    chk("t1_ack", 32'(ack_vec), 32'b0100);
    chk("t1_req_drop", 32'(req_out), 32'd0);
    chk("t1_busy_resp", 32'(busy), 32'd1);
    ack_in  = 1'b0;
    req_vec = 4'b0000;
    tick();
    chk("t1_ack_clear", 32'(ack_vec), 32'd0);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_gid_hold", 32'(gid), 32'd2);

    // Round-robin from a fresh reset
    do_reset();
    req_vec  = 4'b1111;
    addr_vec = 8'b11_10_01_00;
    rr_txn(0);
    rr_txn(1);
    rr_txn(2);
    rr_txn(3);
    req_vec = 4'b1001;
    rr_txn(0);
    rr_txn(3);

    // Timeout: requester 1, ACK_IN held low (last grant is 3, so 1 wins)
    req_vec  = 4'b0010;
    addr_vec = 8'b00_00_01_00;
    tick();
    chk("to_gid", 32'(gid), 32'd1);
    chk("to_req_out_1", 32'(req_out), 32'd1);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk("to_req_out_held", 32'(req_out), 32'd1);
      chk("to_no_err_early", 32'(err_vec), 32'd0);
    end
    tick();
    chk("to_req_out_drop", 32'(req_out), 32'd0);
    chk("to_err", 32'(err_vec), 32'b0010);
    chk("to_no_ack", 32'(ack_vec), 32'd0);
    req_vec = 4'b0000;
    tick();
    chk("to_err_clear", 32'(err_vec), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);

    // ACK on the 15th WAIT cycle wins over the timeout
    req_vec  = 4'b0100;
    addr_vec = 8'b00_01_00_00;
    tick();
    chk("col_gid", 32'(gid), 32'd2);
    for (int i = 2; i <= 15; i++) tick();
    chk("col_still_waiting", 32'(req_out), 32'd1);
    ack_in = 1'b1;
    tick();
    chk("col_ack", 32'(ack_vec), 32'b0100);
    chk("col_no_err", 32'(err_vec), 32'd0);
    ack_in  = 1'b0;
    req_vec = 4'b0000;
    tick();
    chk("col_err_after", 32'(err_vec), 32'd0);
    chk("col_idle", 32'(busy), 32'd0);

    // Winner drops REQ and changes address during WAIT
    req_vec  = 4'b1000;
    addr_vec = 8'b10_00_00_00;
    tick();
    chk("dist_gid", 32'(gid), 32'd3);
    chk("dist_addr", 32'(my_addr), 32'd2);
    req_vec  = 4'b0000;
    addr_vec = 8'b01_11_11_11;
    tick();
    chk("dist_addr_held", 32'(my_addr), 32'd2);
    chk("dist_req_held", 32'(req_out), 32'd1);
    ack_in = 1'b1;
    tick();
    chk("dist_ack", 32'(ack_vec), 32'b1000);
    chk("dist_addr_at_ack", 32'(my_addr), 32'd2);
    ack_in = 1'b0;
    tick();
    chk("dist_idle", 32'(busy), 32'd0);

    // ACK_IN while IDLE has no effect
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_req", 32'(req_out), 32'd0);
    chk("idle_ack_ackvec", 32'(ack_vec), 32'd0);
    chk("idle_ack_err", 32'(err_vec), 32'd0);
    tick();
    chk("idle_ack_still", 32'(busy), 32'd0);

    // Async reset during WAIT; afterwards requester 0 has first priority
    req_vec  = 4'b0001;
    addr_vec = 8'b00_00_00_01;
    tick();
    chk("rm_gid", 32'(gid), 32'd0);
    tick();
    chk("rm_waiting", 32'(req_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_req_out", 32'(req_out), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_gid_rst", 32'(gid), 32'd0);
    chk("rm_no_ack", 32'(ack_vec), 32'd0);
    tick();
    chk("rm_no_err", 32'(err_vec), 32'd0);
    rst     = 1'b0;
    req_vec = 4'b0011;
    tick();
    chk("rm_regrant", 32'(gid), 32'd0);
    chk("rm_regrant_req", 32'(req_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
